// File: rtl/autoc_pkg.sv
// Shared definitions for the windowed autocorrelator: widths, FSM encoding,
// and small elaboration-time helpers.
package autoc_pkg;

    localparam int AUTOC_IW      = 16;
    localparam int AUTOC_LOG_WIN = 4;

    // Product width (one guard bit for the two-term sum) and accumulator width
    localparam int PW = 2*AUTOC_IW + 1;
    localparam int AW = PW + AUTOC_LOG_WIN;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int pw_of(input int iw);
        return 2*iw + 1;
    endfunction

endpackage

// File: rtl/autoc_cmul_conj.sv
// Registered conjugate multiplier: prod = cur * conj(dly), one stage,
// with the matching strobe delayed alongside.
module autoc_cmul_conj
    import autoc_pkg::*;
#(
    parameter int IW = AUTOC_IW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 in_stb_i,
    input  logic signed [IW-1:0] cur_re_i,
    input  logic signed [IW-1:0] cur_im_i,
    input  logic signed [IW-1:0] dly_re_i,
    input  logic signed [IW-1:0] dly_im_i,
    output logic signed [2*IW:0] prod_re_o,
    output logic signed [2*IW:0] prod_im_o,
    output logic                 p_stb_o
);

    localparam int PPW = 2*IW;
    localparam int PRW = pw_of(IW);

    logic signed [PPW-1:0] rr, ii, ri, ir;
    logic signed [PRW-1:0] prod_re_d, prod_im_d;
    logic signed [PRW-1:0] prod_re_q, prod_im_q;
    logic                  p_stb_q;
    logic                  take;

    // Operands widened first so every partial product is exact in 2*IW bits
    assign rr = PPW'(cur_re_i) * PPW'(dly_re_i);
    assign ii = PPW'(cur_im_i) * PPW'(dly_im_i);
    assign ri = PPW'(cur_im_i) * PPW'(dly_re_i);
    assign ir = PPW'(cur_re_i) * PPW'(dly_im_i);

    assign prod_re_d = PRW'(rr) + PRW'(ii);
    assign prod_im_d = PRW'(ri) - PRW'(ir);

    // A clear drops both the incoming sample and anything already in this stage
    assign take = in_stb_i && !clear_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_stb_q   <= 1'b0;
            prod_re_q <= '0;
            prod_im_q <= '0;
        end else begin
            p_stb_q <= take;
            if (take) begin
                prod_re_q <= prod_re_d;
                prod_im_q <= prod_im_d;
            end
        end
    end

    assign prod_re_o = prod_re_q;
    assign prod_im_o = prod_im_q;
    assign p_stb_o   = p_stb_q;

endmodule

// File: rtl/autoc_window_sum.sv
// Sliding-window complex autocorrelator: P[n] = sum of the last WIN products
// x[n]*conj(x[n-D]), kept as a running sum over a circular product history.
module autoc_window_sum
    import autoc_pkg::*;
#(
    parameter int IW      = AUTOC_IW,
    parameter int LOG_WIN = AUTOC_LOG_WIN
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         in_stb,
    input  logic signed [IW-1:0]         cur_i,
    input  logic signed [IW-1:0]         cur_q,
    input  logic signed [IW-1:0]         dly_i,
    input  logic signed [IW-1:0]         dly_q,
    output logic                         out_stb,
    output logic signed [2*IW+LOG_WIN:0] sum_i,
    output logic signed [2*IW+LOG_WIN:0] sum_q,
    output logic                         full
);

    localparam int WIN  = 1 << LOG_WIN;
    localparam int PRW  = pw_of(IW);
    localparam int ACW  = PRW + LOG_WIN;
    localparam int PTRW = clog2(WIN);

    logic signed [PRW-1:0]  prod_re, prod_im;
    logic                   p_stb;

    state_e                 state_q, state_d;
    logic [PTRW-1:0]        cnt_q, cnt_d;
    logic [PTRW-1:0]        wr_ptr_q, wr_ptr_d;
    logic signed [ACW-1:0]  acc_re_q, acc_re_d;
    logic signed [ACW-1:0]  acc_im_q, acc_im_d;
    logic                   out_stb_q, out_stb_d;

    logic signed [PRW-1:0]  hist_re [WIN];
    logic signed [PRW-1:0]  hist_im [WIN];
    logic signed [PRW-1:0]  old_re, old_im;

    autoc_cmul_conj #(.IW(IW)) u_cmul (
        .clk       (clk),
        .rst_n     (reset_n),
        .clear_i   (clear),
        .in_stb_i  (in_stb),
        .cur_re_i  (cur_i),
        .cur_im_i  (cur_q),
        .dly_re_i  (dly_i),
        .dly_im_i  (dly_q),
        .prod_re_o (prod_re),
        .prod_im_o (prod_im),
        .p_stb_o   (p_stb)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FILL;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = FILL;
        else if (p_stb && state_q == FILL && cnt_q == PTRW'(WIN-1))
            state_d = RUN;
    end

    always_comb begin
        full      = (state_q == RUN);
        out_stb_d = !clear && p_stb && (state_d == RUN);
    end

    // The slot at wr_ptr holds the product leaving the window; while filling
    // it is stale and must not be subtracted.
    always_comb begin
        old_re = (state_q == RUN) ? hist_re[wr_ptr_q] : '0;
        old_im = (state_q == RUN) ? hist_im[wr_ptr_q] : '0;
    end

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        if (clear) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            acc_re_d = '0;
            acc_im_d = '0;
        end else if (p_stb) begin
            acc_re_d = acc_re_q + ACW'(prod_re) - ACW'(old_re);
            acc_im_d = acc_im_q + ACW'(prod_im) - ACW'(old_im);
            wr_ptr_d = wr_ptr_q + PTRW'(1);
            if (state_q == FILL) cnt_d = cnt_q + PTRW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            out_stb_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
            out_stb_q <= out_stb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (p_stb && !clear) begin
            hist_re[wr_ptr_q] <= prod_re;
            hist_im[wr_ptr_q] <= prod_im;
        end
    end

    assign out_stb = out_stb_q;
    assign sum_i   = acc_re_q;
    assign sum_q   = acc_im_q;

endmodule

// File: tb/tb_autoc_window_sum.sv
// Self-checking bench for autoc_window_sum (IW=16, WIN=4) against a
// queue-based window-sum model with scheduled expected outputs.
module tb_autoc_window_sum;

    localparam int IW      = 16;
    localparam int LOG_WIN = 2;
    localparam int WIN     = 4;
    localparam int SW      = 2*IW + 1 + LOG_WIN;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 clear;
    logic                 in_stb;
    logic signed [IW-1:0] cur_i, cur_q, dly_i, dly_q;
    logic                 out_stb;
    logic signed [SW-1:0] sum_i, sum_q;
    logic                 full;

    autoc_window_sum #(.IW(IW), .LOG_WIN(LOG_WIN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .in_stb  (in_stb),
        .cur_i   (cur_i),
        .cur_q   (cur_q),
        .dly_i   (dly_i),
        .dly_q   (dly_q),
        .out_stb (out_stb),
        .sum_i   (sum_i),
        .sum_q   (sum_q),
        .full    (full)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int     due;
        longint si;
        longint sq;
        bit     fl;
    } pend_t;

    longint hist_i[$];
    longint hist_q[$];
    pend_t  pend[$];
    bit     e_stb;
    bit     e_full;
    longint e_si, e_sq;

    function automatic void model_flush();
        hist_i.delete();
        hist_q.delete();
        pend.delete();
        e_stb  = 1'b0;
        e_full = 1'b0;
        e_si   = 0;
        e_sq   = 0;
    endfunction

    // One clock of stimulus; afterwards e_* hold what the outputs should show.
    task automatic drive(input bit stb, input bit clr, input int ci, input int cq,
                         input int di, input int dq);
        pend_t  p;
        longint pi, pq, si, sq;
        in_stb = stb;
        clear  = clr;
        cur_i  = ci[IW-1:0];
        cur_q  = cq[IW-1:0];
        dly_i  = di[IW-1:0];
        dly_q  = dq[IW-1:0];
        @(posedge clk);
        #1;
        cyc++;
        if (clr) begin
            model_flush();
        end else begin
            e_stb = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p      = pend.pop_front();
                e_si   = p.si;
                e_sq   = p.sq;
                e_full = p.fl;
                e_stb  = p.fl;
            end
            if (stb) begin
                pi = longint'(ci)*longint'(di) + longint'(cq)*longint'(dq);
                pq = longint'(cq)*longint'(di) - longint'(ci)*longint'(dq);
                hist_i.push_back(pi);
                hist_q.push_back(pq);
                if (hist_i.size() > WIN) begin
                    void'(hist_i.pop_front());
                    void'(hist_q.pop_front());
                end
                si = 0;
                sq = 0;
                foreach (hist_i[k]) begin
                    si += hist_i[k];
                    sq += hist_q[k];
                end
                p.due = cyc + 1;
                p.si  = si;
                p.sq  = sq;
                p.fl  = (hist_i.size() == WIN);
                pend.push_back(p);
            end
        end
        in_stb = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_stb !== 1'b0 || full !== 1'b0 || sum_i !== '0 || sum_q !== '0) begin
            failures++;
            $display("FAIL reset_state got stb=%b full=%b si=%0d sq=%0d want all 0",
                     out_stb, full, sum_i, sum_q);
        end
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        model_flush();
        @(posedge clk);
        #1;
    endtask

    // Unit products: first output after 4th strobe with sum (4,0)
    task automatic test_fill();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 1, 0, 1, 0);
            checks++;
            if (out_stb !== e_stb || full !== e_full) begin
                failures++;
                $display("FAIL fill_ctl k=%0d got stb=%b full=%b want stb=%b full=%b",
                         k, out_stb, full, e_stb, e_full);
            end
            if (e_stb) begin
                checks++;
                if (longint'(sum_i) != e_si || longint'(sum_q) != e_sq) begin
                    failures++;
                    $display("FAIL fill_sum k=%0d got (%0d,%0d) want (%0d,%0d)",
                             k, sum_i, sum_q, e_si, e_sq);
                end
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (out_stb !== (k == 4) || full !== (k == 4) ||
                    (k == 4 && (sum_i !== 35'sd4 || sum_q !== 35'sd0))) begin
                    failures++;
                    $display("FAIL fill_first k=%0d got stb=%b full=%b sum=(%0d,%0d) want first at k=4 sum=(4,0)",
                             k, out_stb, full, sum_i, sum_q);
                end
            end
        end
    endtask

    // Switch to purely imaginary products: window drains (3,1)..(0,4)
    task automatic test_slide();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 0, 1, 1, 0);
            checks++;
            if (out_stb !== e_stb || longint'(sum_i) != e_si || longint'(sum_q) != e_sq) begin
                failures++;
                $display("FAIL slide k=%0d got stb=%b (%0d,%0d) want stb=%b (%0d,%0d)",
                         k, out_stb, sum_i, sum_q, e_stb, e_si, e_sq);
            end
            if (k >= 1 && k <= 5) begin
                checks++;
                if (out_stb !== 1'b1 || longint'(sum_i) != longint'(4 - ((k > 4) ? 4 : k)) ||
                    longint'(sum_q) != longint'((k > 4) ? 4 : k)) begin
                    failures++;
                    $display("FAIL slide_seq k=%0d got (%0d,%0d) want (%0d,%0d)",
                             k, sum_i, sum_q, 4 - ((k > 4) ? 4 : k), (k > 4) ? 4 : k);
                end
            end
        end
    endtask

    task automatic test_fullscale();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, -32768, -32768, -32768, -32768);
            checks++;
            if (out_stb !== e_stb || longint'(sum_i) != e_si || longint'(sum_q) != e_sq) begin
                failures++;
                $display("FAIL fullscale k=%0d got stb=%b (%0d,%0d) want stb=%b (%0d,%0d)",
                         k, out_stb, sum_i, sum_q, e_stb, e_si, e_sq);
            end
        end
        checks++;
        if (out_stb !== 1'b1 || longint'(sum_i) != 64'sd8589934592 || longint'(sum_q) != 0) begin
            failures++;
            $display("FAIL fullscale_abs got stb=%b (%0d,%0d) want (8589934592,0)",
                     out_stb, sum_i, sum_q);
        end
    endtask

    task automatic test_random_gaps();
        int gap;
        for (int s = 0; s < 40; s++) begin
            drive(1'b1, 1'b0, int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768);
            gap = int'($urandom_range(1, 5));
            for (int g = 0; g <= gap; g++) begin
                if (g > 0) drive(1'b0, 1'b0, 0, 0, 0, 0);
                checks++;
                if (out_stb !== e_stb || full !== e_full) begin
                    failures++;
                    $display("FAIL rand_ctl s=%0d g=%0d got stb=%b full=%b want stb=%b full=%b",
                             s, g, out_stb, full, e_stb, e_full);
                end
                if (e_stb) begin
                    checks++;
                    if (longint'(sum_i) != e_si || longint'(sum_q) != e_sq) begin
                        failures++;
                        $display("FAIL rand_sum s=%0d got (%0d,%0d) want (%0d,%0d)",
                                 s, sum_i, sum_q, e_si, e_sq);
                    end
                end
            end
        end
    endtask

    // Back-to-back strobes, clear lands on one of them in RUN
    task automatic test_clear();
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 3, -2, 1, 5);
        drive(1'b1, 1'b1, 7, 7, 7, 7);
        checks++;
        if (out_stb !== 1'b0 || full !== 1'b0 || sum_i !== '0 || sum_q !== '0) begin
            failures++;
            $display("FAIL clear_now got stb=%b full=%b (%0d,%0d) want 0,0,(0,0)",
                     out_stb, full, sum_i, sum_q);
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, k + 1, -k, 2, k - 3);
            checks++;
            if (out_stb !== e_stb || full !== e_full ||
                longint'(sum_i) != e_si || longint'(sum_q) != e_sq) begin
                failures++;
                $display("FAIL clear_refill k=%0d got stb=%b full=%b (%0d,%0d) want stb=%b full=%b (%0d,%0d)",
                         k, out_stb, full, sum_i, sum_q, e_stb, e_full, e_si, e_sq);
            end
            if (k <= 4) begin
                checks++;
                if (out_stb !== (k == 4)) begin
                    failures++;
                    $display("FAIL clear_first k=%0d got stb=%b want %b", k, out_stb, k == 4);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, 9, 4, -3, 2);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_stb !== 1'b0 || full !== 1'b0 || sum_i !== '0 || sum_q !== '0) begin
            failures++;
            $display("FAIL async_reset got stb=%b full=%b (%0d,%0d) want all 0",
                     out_stb, full, sum_i, sum_q);
        end
        model_flush();
        #3 reset_n = 1'b1;
        test_fill();
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        in_stb  = 1'b0;
        cur_i   = '0;
        cur_q   = '0;
        dly_i   = '0;
        dly_q   = '0;
        model_flush();
        test_reset();
        test_fill();
        test_slide();
        test_fullscale();
        test_random_gaps();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
